mem_responder: RTL
==================

# mem_responder

Memory-side responder for the multi-cycle CPU: consumes the control unit's one-step memory strobes (InstRead, MemRead, MemWrite) and serves them from a unified word-addressed instruction/data store. It supports a configurable number of wait states and returns a one-cycle `ready` pulse. It also returns the fetched instruction (for `ldIR`) and the load data (for `RegWrite` of `lw`). It sits between the control unit/datapath and the storage array.

## Interface
- `DEPTH`, 32: number of 32-bit words; power of two.
- `AW`, 5: word-index width, log2(DEPTH).
- `LAT`, 0: wait states per access, 0..7. With 0, data is valid one step after the strobe, matching the control unit's step spacing.

- `clk`  in  1  system clock. Everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `InstRead`  in  1  instruction-fetch strobe; address is `pc`.
- `MemRead`  in  1  data-load strobe; address is `addr`.
- `MemWrite`  in  1  data-store strobe; address is `addr`, data is `wdata`.
- `pc`  in  32  byte address for fetch.
- `addr`  in  32  byte address for load/store.
- `wdata`  in  32  store data.
- `inst`  out  32  last fetched instruction; held until the next fetch completes.
- `rdata`  out  32  last load data; held until the next load completes.
- `ready`  out  1  one-cycle pulse marking completion of an access.
- `busy`  out  1  high while an accepted access is waiting out its wait states.
- `err`  out  1  one-cycle pulse coincident with `ready` when the completed access was flagged.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - WAIT: counts wait states.
- Acceptance: strobes are sampled only in IDLE. An edge with any strobe high is the acceptance edge E0.
- Latching at E0: the access captures its kind, word index, alignment, and `wdata`.
- Priority when several strobes are high at E0: InstRead > MemWrite > MemRead.
  - Only the winner is performed.
  - The losers are dropped and the access is flagged.
- Addressing:
  - Word index is `byte_addr[AW+1:2]`.
  - Upper bits are ignored, so addresses wrap modulo DEPTH words.
- Misaligned access (`byte_addr[1:0] != 0`) is flagged:
  - Store: no write is performed.
  - Fetch or load: the destination register is loaded with 0.
- Completion:
  - On completion, a fetch updates `inst`, a load updates `rdata`, and a store commits to the array. A store does not change `inst` or `rdata`.
  - The array is read at the completion edge, so a store followed by a load of the same word returns the new data.
- Overrun: a strobe that arrives while in WAIT is ignored and flags the in-flight access.
- Completion cycle: the cycle after completion is back in IDLE, and a new strobe there is accepted normally.
- Array contents are not affected by reset.
- Reset values: `inst`=0, `rdata`=0, `ready`=0, `busy`=0, `err`=0, state IDLE, counter 0.
- Reset mid-access abandons the access. A pending store is not committed.

## Timing
- LAT=0:
  - The access completes at E0; there is no WAIT state.
  - `ready` (and `err` if flagged) is high for the single cycle after E0, with `inst`/`rdata` already valid.
  - `busy` never rises.
- LAT=n>0:
  - The FSM enters WAIT at E0 with counter=n and decrements it each edge.
  - The access completes at edge E0+n, when the counter reaches 1 and goes to 0, and the FSM returns to IDLE.
  - `busy` is high from after E0 until edge E0+n.
  - `ready` is high for the cycle after E0+n.
- Throughput: at most one access every LAT+1 cycles.
- `ready`, `busy`, `err`, `inst`, and `rdata` are all registered outputs.
- Read data is registered, not combinational from the address.

## Structure
- Shared package `cpu_pkg`:
  - Word-width constant 32.
  - Access-kind enum: ACC_FETCH, ACC_LOAD, ACC_STORE.
  - FSM state enum: ST_IDLE, ST_WAIT.
- One natural sub-module, `mem_array`: single-port synchronous DEPTH×32 storage with write enable. It has no reset and is initialised to zero at elaboration.
- `mem_responder` owns the FSM, counter, priority/flag logic, and output registers.

## Test plan
- Fetch, LAT=0: preload word 3 = 0x8C22_0004; pulse InstRead with pc=0x0C → `inst`=0x8C22_0004 and `ready`=1 exactly one cycle later; `err`=0; `busy` stays 0.
- Store then load, LAT=2: MemWrite addr=0x10, wdata=0xDEAD_BEEF; after `ready`, MemRead addr=0x10 → `busy` high for 2 cycles, then `rdata`=0xDEAD_BEEF with `ready` 3 cycles after the load strobe.
- Priority: InstRead and MemWrite together (pc=0, addr=0x04, wdata=0x1234) → fetch performed; word 1 unchanged; `ready` and `err` pulse together.
- Misaligned and wrap, DEPTH=32:
  - MemWrite at addr=0x06 → `err` pulses and no word changes.
  - MemRead at addr=0x84 returns word 1.
- Overrun, LAT=3: MemRead accepted, then InstRead pulsed during WAIT → the InstRead is ignored; `inst` is unchanged; completion shows `ready`=1, `err`=1.
- Reset mid-access, LAT=4: MemWrite to word 5 = 0xFFFF_FFFF; drop `rst_n` at cycle 2 → all outputs 0 immediately (asynchronous); a later load of word 5 returns its old value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle CPU memory path: word width, access kinds,
// and responder FSM states.
package cpu_pkg;

  localparam int unsigned WordWidth = 32;

  typedef enum logic [1:0] {
    ACC_FETCH,
    ACC_LOAD,
    ACC_STORE
  } acc_kind_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x 32 word store with synchronous write. No reset; contents
// start at zero. The read port is combinational and registered by the user.
module mem_array
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        idx,
  input  logic [WordWidth-1:0] wdata,
  output logic [WordWidth-1:0] rdata
);

  logic [WordWidth-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Serves the control unit's fetch/load/store strobes from a unified word store
// with LAT wait states, returning registered inst/rdata and a ready pulse.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned LAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 InstRead,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [WordWidth-1:0] pc,
  input  logic [WordWidth-1:0] addr,
  input  logic [WordWidth-1:0] wdata,
  output logic [WordWidth-1:0] inst,
  output logic [WordWidth-1:0] rdata,
  output logic                 ready,
  output logic                 busy,
  output logic                 err
);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  acc_kind_e            kind_q, kind_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 mis_q, mis_d;
  logic                 flag_q, flag_d;
  logic [WordWidth-1:0] wdata_q, wdata_d;

  logic [WordWidth-1:0] inst_q, rdata_q;
  logic                 ready_q, busy_q, err_q;

  logic                 any_strobe, multi;
  acc_kind_e            live_kind;
  logic [WordWidth-1:0] live_byte;
  logic                 live_mis;

  logic                 done;
  acc_kind_e            done_kind;
  logic [AW-1:0]        done_idx;
  logic                 done_mis, done_flag;
  logic [WordWidth-1:0] done_wdata;

  logic                 mem_we;
  logic [WordWidth-1:0] mem_rd;
  logic                 unused_upper;

  assign any_strobe = InstRead | MemRead | MemWrite;
  assign multi      = (InstRead & (MemRead | MemWrite)) | (MemRead & MemWrite);
  assign live_byte  = InstRead ? pc : addr;
  assign live_mis   = |live_byte[1:0];
  // Addresses wrap modulo DEPTH words; the upper byte-address bits are ignored.
  assign unused_upper = ^live_byte[WordWidth-1:AW+2];

  always_comb begin
    if (InstRead) begin
      live_kind = ACC_FETCH;
    end else if (MemWrite) begin
      live_kind = ACC_STORE;
    end else begin
      live_kind = ACC_LOAD;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    idx_d      = idx_q;
    mis_d      = mis_q;
    flag_d     = flag_q;
    wdata_d    = wdata_q;
    done       = 1'b0;
    done_kind  = kind_q;
    done_idx   = idx_q;
    done_mis   = mis_q;
    done_flag  = flag_q;
    done_wdata = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_strobe) begin
          if (LAT == 0) begin
            // Zero wait states: complete on the acceptance edge from live inputs.
            done       = 1'b1;
            done_kind  = live_kind;
            done_idx   = live_byte[AW+1:2];
            done_mis   = live_mis;
            done_flag  = multi | live_mis;
            done_wdata = wdata;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 3'(LAT);
            kind_d  = live_kind;
            idx_d   = live_byte[AW+1:2];
            mis_d   = live_mis;
            flag_d  = multi | live_mis;
            wdata_d = wdata;
          end
        end
      end
      ST_WAIT: begin
        // Any strobe seen while waiting is an overrun against the in-flight access.
        flag_d    = flag_q | any_strobe;
        done_flag = flag_q | any_strobe;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we = done & (done_kind == ACC_STORE) & ~done_mis & rst_n;

  mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .idx  (done_idx),
    .wdata(done_wdata),
    .rdata(mem_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kind_q  <= ACC_FETCH;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      flag_q  <= 1'b0;
      wdata_q <= '0;
      inst_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      flag_q  <= flag_d;
      wdata_q <= wdata_d;
      ready_q <= done;
      err_q   <= done & done_flag;
      busy_q  <= (state_d == ST_WAIT);
      if (done && (done_kind == ACC_FETCH)) begin
        inst_q <= done_mis ? '0 : mem_rd;
      end
      if (done && (done_kind == ACC_LOAD)) begin
        rdata_q <= done_mis ? '0 : mem_rd;
      end
    end
  end

  assign inst  = inst_q;
  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
